// File: rtl/selector_result_queue.sv
// Result queue behind the operation selector: FWFT FIFO of {tag, data} with a
// valid/ready interface, a saturating running sum and sticky debug flags.
module selector_result_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ACC_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ACC_W-1:0]         acc_sum,
  output logic                     acc_ovf,
  output logic                     tag_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = TAG_W + DATA_W;
  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             tag_err_q, tag_err_d;

  logic             accept;
  logic             tag_onehot;
  logic             store;
  logic             pop;
  logic [ACC_W-1:0] acc_base;
  logic [SUM_W-1:0] sum_ext;
  logic [ENT_W-1:0] head;

  // Handshake decode; in_ready and out_valid depend on registered count only.
  always_comb begin
    in_ready   = (count_q != CNT_W'(DEPTH));
    out_valid  = (count_q != CNT_W'(0));
    accept     = in_valid & in_ready;
    tag_onehot = (in_tag != '0) && ((in_tag & (in_tag - TAG_W'(1))) == '0);
    store      = accept & tag_onehot;
    pop        = out_valid & out_ready;
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (store) begin
      mem_d[wr_ptr_q] = {in_tag, in_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (store && !pop)      count_d = count_q + CNT_W'(1);
    else if (!store && pop) count_d = count_q - CNT_W'(1);
  end

  // Accumulator: clear applies before the add when both happen together.
  always_comb begin
    acc_base  = acc_clr ? '0 : acc_sum_q;
    sum_ext   = {1'b0, acc_base} + SUM_W'(in_data);
    acc_sum_d = acc_base;
    acc_ovf_d = acc_clr ? 1'b0 : acc_ovf_q;
    tag_err_d = tag_err_q | (accept & ~tag_onehot);
    if (store) begin
      if (sum_ext[ACC_W]) begin
        acc_sum_d = '1;
        acc_ovf_d = 1'b1;
      end else begin
        acc_sum_d = sum_ext[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      acc_sum_q <= '0;
      acc_ovf_q <= 1'b0;
      tag_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      acc_sum_q <= acc_sum_d;
      acc_ovf_q <= acc_ovf_d;
      tag_err_q <= tag_err_d;
    end
  end

  // FWFT head read, forced to zero while empty.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    out_data = out_valid ? head[DATA_W-1:0] : '0;
    out_tag  = out_valid ? head[ENT_W-1:DATA_W] : '0;
    count    = count_q;
    acc_sum  = acc_sum_q;
    acc_ovf  = acc_ovf_q;
    tag_err  = tag_err_q;
  end

endmodule

// File: tb/tb_selector_result_queue.sv
// Bench for selector_result_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_selector_result_queue;

  localparam int DEPTH = 4;
  localparam int ACC_MAX = 4095;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_tag = '0;
  logic       acc_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] out_tag;
  logic [2:0] count;
  logic [11:0] acc_sum;
  logic       acc_ovf;
  logic       tag_err;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [11:0] m_q[$];
  int          m_sum = 0;
  bit          m_ovf = 0;
  bit          m_err = 0;

  selector_result_queue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .count(count), .acc_sum(acc_sum), .acc_ovf(acc_ovf), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_sum = 0;
    m_ovf = 0;
    m_err = 0;
  endtask

  // One clock with the current inputs; model advances by the same rules.
  task automatic tick();
    bit acc, st, pp;
    acc = in_valid && (m_q.size() != DEPTH);
    st  = acc && ($countones(in_tag) == 1);
    pp  = out_ready && (m_q.size() != 0);
    @(posedge clk);
    #1;
    if (pp) void'(m_q.pop_front());
    if (st) m_q.push_back({in_tag, in_data});
    if (acc && !st) m_err = 1;
    if (acc_clr) begin m_sum = 0; m_ovf = 0; end
    if (st) begin
      m_sum = m_sum + int'(in_data);
      if (m_sum > ACC_MAX) begin m_sum = ACC_MAX; m_ovf = 1; end
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] t);
    in_valid = 1'b1; in_data = d; in_tag = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++;
    if ({out_valid, count, acc_sum, acc_ovf, tag_err, out_data, out_tag} !== '0) begin
      bad++; $display("FAIL reset_state got v=%b c=%0d s=%h o=%b e=%b d=%h t=%b exp all zero",
                      out_valid, count, acc_sum, acc_ovf, tag_err, out_data, out_tag);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    push(8'hF0, 4'b0010);
    total++;
    if ({out_valid, out_data, out_tag, count, acc_sum} !== {1'b1, 8'hF0, 4'b0010, 3'd1, 12'h0F0}) begin
      bad++; $display("FAIL single_head got v=%b d=%h t=%b c=%0d s=%h exp 1/f0/0010/1/0f0",
                      out_valid, out_data, out_tag, count, acc_sum);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++;
    if ({count, out_valid} !== {3'd0, 1'b0}) begin
      bad++; $display("FAIL single_pop got c=%0d v=%b exp 0/0", count, out_valid);
    end
  endtask

  task automatic test_fill();
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(i + 1), 4'(1 << i));
    total++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      bad++; $display("FAIL fill_full got c=%0d r=%b exp 4/0", count, in_ready);
    end
    push(8'h05, 4'b0001);
    total++;
    if ({count, out_data} !== {3'd4, 8'h01}) begin
      bad++; $display("FAIL fill_reject got c=%0d d=%h exp 4/01", count, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_valid, out_data, out_tag} !== {1'b1, 8'(i + 1), 4'(1 << i)}) begin
        bad++; $display("FAIL fill_order[%0d] got v=%b d=%h t=%b exp 1/%h/%b",
                        i, out_valid, out_data, out_tag, 8'(i + 1), 4'(1 << i));
      end
      tick();
    end
    out_ready = 1'b0;
    total++;
    if ({count, acc_sum} !== {3'd0, 12'h00A}) begin
      bad++; $display("FAIL fill_drain got c=%0d s=%h exp 0/00a", count, acc_sum);
    end
  endtask

  task automatic test_back_to_back();
    push(8'h10, 4'b0001);
    push(8'h11, 4'b0010);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({out_data, count} !== {8'(8'h10 + i), 3'd2}) begin
        bad++; $display("FAIL b2b_head[%0d] got d=%h c=%0d exp %h/2", i, out_data, count, 8'(8'h10 + i));
      end
      push(8'(8'h12 + i), 4'(1 << (i % 4)));
    end
    total++;
    if (count !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
    tick(); tick();
    out_ready = 1'b0;
  endtask

  task automatic test_bad_tag();
    logic [2:0]  c0;
    logic [11:0] s0;
    c0 = 3'(m_q.size()); s0 = 12'(m_sum);
    in_valid = 1'b1; in_data = 8'h55; in_tag = 4'b0011;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL badtag_ready got=%b exp=1", in_ready); end
    tick();
    in_data = 8'h66; in_tag = 4'b0000;
    tick();
    in_valid = 1'b0;
    total++;
    if ({count, acc_sum, tag_err} !== {c0, s0, 1'b1}) begin
      bad++; $display("FAIL badtag_drop got c=%0d s=%h e=%b exp %0d/%h/1", count, acc_sum, tag_err, c0, s0);
    end
    push(8'h01, 4'b1000);
    total++;
    if ({tag_err, count} !== {1'b1, 3'(c0 + 1)}) begin
      bad++; $display("FAIL badtag_sticky got e=%b c=%0d exp 1/%0d", tag_err, count, c0 + 1);
    end
    out_ready = 1'b1; repeat (DEPTH) tick(); out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'hFF, 4'b0001);
    total++;
    if ({acc_sum, acc_ovf} !== {12'hFFF, 1'b1}) begin
      bad++; $display("FAIL sat_clip got s=%h o=%b exp fff/1", acc_sum, acc_ovf);
    end
    acc_clr = 1'b1; push(8'h07, 4'b0100); acc_clr = 1'b0;
    total++;
    if ({acc_sum, acc_ovf} !== {12'h007, 1'b0}) begin
      bad++; $display("FAIL sat_clr_add got s=%h o=%b exp 007/0", acc_sum, acc_ovf);
    end
    repeat (2) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 4'b0010);
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL midrst_pre got c=%0d exp 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, count, acc_sum, acc_ovf, tag_err} !== '0) begin
      bad++; $display("FAIL midrst_async got v=%b c=%0d s=%h o=%b e=%b exp zeros",
                      out_valid, count, acc_sum, acc_ovf, tag_err);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(8'hA5, 4'b0100);
    total++;
    if ({out_valid, out_data, out_tag, count} !== {1'b1, 8'hA5, 4'b0100, 3'd1}) begin
      bad++; $display("FAIL midrst_after got v=%b d=%h t=%b c=%0d exp 1/a5/0100/1",
                      out_valid, out_data, out_tag, count);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    logic [11:0] h;
    int r;
    for (int n = 0; n < 400; n++) begin
      h = (m_q.size() != 0) ? m_q[0] : 12'h000;
      got = {8'h00, in_ready, out_valid, out_data, out_tag, count, acc_sum, acc_ovf, tag_err};
      exp = {8'h00, 1'(m_q.size() != DEPTH), 1'(m_q.size() != 0), h[7:0], h[11:8],
             3'(m_q.size()), 12'(m_sum), m_ovf, m_err};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random[%0d] got=%h exp=%h", n, got, exp);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      r = $urandom_range(0, 15);
      in_tag    = (r < 14) ? 4'(1 << (r % 4)) : 4'($urandom);
      acc_clr   = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_bad_tag();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
